alu_result_collector: RTL and testbench
=======================================

# alu_result_collector

Downstream stage of the tinyalu stimulus path: captures every `result` the ALU presents with `done` and packs consecutive results LSB-first into one wide batch word. A batch is handed to the host/testbench side through a valid/ready register slot. The batch width mirrors the stimulus side: 20 operations per batch. The block double-buffers, so one batch can be drained while the next fills, and it reports (never stalls on) lost results.

## Interface

- `RES_W`, 16, width of one ALU result
- `PACK_N`, 20, results per full batch
- `TIMEOUT_CYC`, 64, idle cycles before auto-flush (only with `RESCOL_TIMEOUT_EN`)
- `clk_i`  in  1  clock, rising edge
- `reset_i`  in  1  asynchronous, active-low reset
- `done_i`  in  1  ALU result valid; sampled every rising edge
- `result_i`  in  RES_W  ALU result, valid when `done_i`=1
- `flush_i`  in  1  one-cycle request to emit a partial batch
- `out_data_o`  out  PACK_N*RES_W  packed batch; result k at bits [k*RES_W +: RES_W]
- `out_count_o`  out  $clog2(PACK_N+1)  number of valid results in `out_data_o`
- `out_valid_o`  out  1  batch slot occupied
- `out_ready_i`  in  1  consumer accepts the batch
- `overflow_o`  out  1  sticky: at least one result dropped
- `drop_cnt_o`  out  16  dropped-result count, saturates at 16'hFFFF

## Operation

- Fill buffer: `fill_q` (PACK_N*RES_W) plus `fill_cnt` (0..PACK_N).
  - Each edge with `done_i`=1 and `fill_cnt`<PACK_N writes `result_i` at slot `fill_cnt` and increments `fill_cnt`.
  - Unwritten slots read as 0.
- The output slot is free when `out_valid_o`=0, or when `out_valid_o`=1 and `out_ready_i`=1 in the same cycle (pass-through accept).
- Transfer condition is `send` = slot free AND one of:
  - the effective count (`fill_cnt` + capture this cycle) equals PACK_N;
  - `flush_pend`=1 and the effective count is greater than 0.
- On transfer:
  - the output registers load the fill contents, including any result captured this cycle;
  - `out_count_o` loads the effective count;
  - `fill_q` and `fill_cnt` clear to 0;
  - `flush_pend` clears.
- `flush_i`=1 sets `flush_pend`.
  - Flush with an empty buffer and no capture in that cycle: `flush_pend` clears and nothing is emitted.
  - Flush while the slot is occupied: `flush_pend` is held until a transfer occurs.
- Drop condition: `done_i`=1 while `fill_cnt`=PACK_N and no transfer occurs that cycle.
  - The result is discarded.
  - `overflow_o` is set and `drop_cnt_o` is incremented, saturating.
  - `fill_q` is unchanged.
- If `fill_cnt`=PACK_N and the slot frees while `done_i`=1: the full buffer transfers and the new result lands at slot 0 with `fill_cnt`=1. Nothing is dropped.
- `overflow_o` and `drop_cnt_o` clear only on reset.

## Timing

- Reset values: `out_data_o`=0, `out_count_o`=0, `out_valid_o`=0, `overflow_o`=0, `drop_cnt_o`=0, `fill_cnt`=0, `flush_pend`=0, timeout counter=0.
- Reset is asynchronous: asserting `reset_i` mid-batch discards the fill buffer and the output slot immediately.
- Latency: `out_valid_o` rises on the edge that captures the PACK_N-th result. It is visible in the cycle after `done_i` for that result.
- Back-to-back operation: with `out_ready_i` held at 1, a continuous `done_i` stream emits a batch every PACK_N cycles with zero drops.
- Handshake: `out_data_o` and `out_count_o` are stable while `out_valid_o`=1 and `out_ready_i`=0. Transfer completes on an edge where both are 1.
- `out_valid_o` never depends combinationally on `out_ready_i`.

## Configuration

- `RESCOL_TIMEOUT_EN` defined:
  - a counter counts cycles with `fill_cnt`>0 and `done_i`=0, and resets on any capture or transfer;
  - on reaching `TIMEOUT_CYC` it sets `flush_pend`, with the same behaviour as `flush_i`.
- `RESCOL_TIMEOUT_EN` undefined:
  - no counter is present;
  - partial batches leave only via `flush_i`;
  - `TIMEOUT_CYC` is ignored.

## Test plan

- Reset, then 20 consecutive `done_i` pulses with results 0x0001..0x0014 and `out_ready_i`=1:
  - one batch, `out_count_o`=20;
  - bits[15:0]=0x0001, bits[319:304]=0x0014;
  - `out_valid_o` high for one cycle, no drops.
- 7 results (0xA000..0xA006) then `flush_i`:
  - `out_count_o`=7, slots 0..6 hold 0xA000..0xA006, slots 7..19=0;
  - the next batch starts at slot 0.
- `out_ready_i`=0, 45 results:
  - first batch held stable, fill buffer full;
  - 5 drops, `overflow_o`=1, `drop_cnt_o`=5;
  - raise `out_ready_i` with `done_i`=1: full buffer transfers and the new result lands at slot 0.
- `flush_i` with empty buffer: no `out_valid_o`. `flush_i` coinciding with a single `done_i` (0xBEEF): batch of count 1 holding 0xBEEF.
- Assert `reset_i` asynchronously mid-batch (count 12) with `out_valid_o`=1: all outputs return to reset values within the same cycle, and the next 20 results form a clean batch.
- With `RESCOL_TIMEOUT_EN`, `TIMEOUT_CYC`=64: 3 results then idle. Batch of count 3 is emitted after exactly 64 idle cycles. Without the macro, nothing is emitted after 200 idle cycles.

Source files
------------

// File: rtl/alu_result_collector.sv
// Packs consecutive ALU results LSB-first into PACK_N-wide batches behind a valid/ready slot.
// Optional idle auto-flush is enabled by defining RESCOL_TIMEOUT_EN.
module alu_result_collector #(
  parameter int unsigned RES_W       = 16,
  parameter int unsigned PACK_N      = 20,
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic                        done_i,
  input  logic [RES_W-1:0]            result_i,
  input  logic                        flush_i,
  output logic [PACK_N*RES_W-1:0]     out_data_o,
  output logic [$clog2(PACK_N+1)-1:0] out_count_o,
  output logic                        out_valid_o,
  input  logic                        out_ready_i,
  output logic                        overflow_o,
  output logic [15:0]                 drop_cnt_o
);

  localparam int unsigned DataW = PACK_N * RES_W;
  localparam int unsigned CntW  = $clog2(PACK_N + 1);

  logic [DataW-1:0] fill_q, fill_d, fill_eff;
  logic [CntW-1:0]  fill_cnt_q, fill_cnt_d, eff_cnt;
  logic             flush_pend_q, flush_pend_d;
  logic [DataW-1:0] out_data_q, out_data_d;
  logic [CntW-1:0]  out_count_q, out_count_d;
  logic             out_valid_q, out_valid_d;
  logic             overflow_q, overflow_d;
  logic [15:0]      drop_cnt_q, drop_cnt_d;

  logic slot_free, full, cap, send, drop, tmo_hit;

  assign slot_free = !out_valid_q || out_ready_i;
  assign full      = (fill_cnt_q == CntW'(PACK_N));
  assign cap       = done_i && !full;
  assign eff_cnt   = fill_cnt_q + CntW'(cap);
  assign send      = slot_free &&
                     ((eff_cnt == CntW'(PACK_N)) || (flush_pend_q && (eff_cnt != '0)));
  assign drop      = done_i && full && !send;

  // Fill contents including a result captured this cycle, so a transfer can forward it.
  always_comb begin
    fill_eff = fill_q;
    for (int unsigned k = 0; k < PACK_N; k++) begin
      if (cap && (fill_cnt_q == CntW'(k))) begin
        fill_eff[k*RES_W +: RES_W] = result_i;
      end
    end
  end

`ifdef RESCOL_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(TIMEOUT_CYC + 1);
  logic [TmoW-1:0] tmo_q, tmo_d;
  logic            idle;

  assign idle    = (fill_cnt_q != '0) && !done_i;
  assign tmo_hit = idle && (tmo_q == TmoW'(TIMEOUT_CYC - 1));

  always_comb begin
    tmo_d = tmo_q;
    if (cap || send) begin
      tmo_d = '0;
    end else if (idle) begin
      if (tmo_q != TmoW'(TIMEOUT_CYC)) tmo_d = tmo_q + 1'b1;
    end else if (fill_cnt_q == '0) begin
      tmo_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) tmo_q <= '0;
    else          tmo_q <= tmo_d;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    fill_d       = fill_eff;
    fill_cnt_d   = eff_cnt;
    flush_pend_d = flush_pend_q;
    out_data_d   = out_data_q;
    out_count_d  = out_count_q;
    out_valid_d  = out_valid_q;
    overflow_d   = overflow_q;
    drop_cnt_d   = drop_cnt_q;

    if (out_valid_q && out_ready_i) out_valid_d = 1'b0;

    if (send) begin
      out_data_d   = fill_eff;
      out_count_d  = eff_cnt;
      out_valid_d  = 1'b1;
      fill_d       = '0;
      fill_cnt_d   = '0;
      flush_pend_d = 1'b0;
      // Full buffer leaving while a new result arrives: it starts the next batch.
      if (done_i && full) begin
        fill_d[RES_W-1:0] = result_i;
        fill_cnt_d        = CntW'(1);
      end
    end else if (flush_pend_q || flush_i || tmo_hit) begin
      flush_pend_d = (eff_cnt != '0);
    end

    if (drop) begin
      overflow_d = 1'b1;
      if (drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      fill_q       <= '0;
      fill_cnt_q   <= '0;
      flush_pend_q <= 1'b0;
      out_data_q   <= '0;
      out_count_q  <= '0;
      out_valid_q  <= 1'b0;
      overflow_q   <= 1'b0;
      drop_cnt_q   <= '0;
    end else begin
      fill_q       <= fill_d;
      fill_cnt_q   <= fill_cnt_d;
      flush_pend_q <= flush_pend_d;
      out_data_q   <= out_data_d;
      out_count_q  <= out_count_d;
      out_valid_q  <= out_valid_d;
      overflow_q   <= overflow_d;
      drop_cnt_q   <= drop_cnt_d;
    end
  end

  assign out_data_o  = out_data_q;
  assign out_count_o = out_count_q;
  assign out_valid_o = out_valid_q;
  assign overflow_o  = overflow_q;
  assign drop_cnt_o  = drop_cnt_q;

endmodule

// File: tb/tb_alu_result_collector.sv
// Randomized and directed bench for alu_result_collector against a queue-based batch model.
module tb_alu_result_collector;

  localparam int RW  = 16;
  localparam int PN  = 20;
  localparam int DW  = PN * RW;
  localparam int CW  = $clog2(PN + 1);
  localparam int TMO = 64;

  logic          clk_i = 1'b0;
  logic          reset_i;
  logic          done_i, flush_i, out_ready_i;
  logic [RW-1:0] result_i;
  logic [DW-1:0] out_data_o;
  logic [CW-1:0] out_count_o;
  logic          out_valid_o, overflow_o;
  logic [15:0]   drop_cnt_o;

  alu_result_collector #(.RES_W(RW), .PACK_N(PN), .TIMEOUT_CYC(TMO)) dut (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .done_i      (done_i),
    .result_i    (result_i),
    .flush_i     (flush_i),
    .out_data_o  (out_data_o),
    .out_count_o (out_count_o),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .overflow_o  (overflow_o),
    .drop_cnt_o  (drop_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: a batch is simply a queue of results.
  logic [RW-1:0] m_fill[$];
  logic [RW-1:0] m_out[$];
  bit            m_pend, m_valid, m_ovf;
  int            m_drops, m_idle;
  int            valid_cycles;

  function automatic logic [DW-1:0] pack(input logic [RW-1:0] q[$]);
    logic [DW-1:0] r = '0;
    for (int i = 0; i < q.size(); i++) r[i*RW +: RW] = q[i];
    return r;
  endfunction

  task automatic model_reset();
    m_fill.delete();
    m_out.delete();
    m_pend = 0; m_valid = 0; m_ovf = 0; m_drops = 0; m_idle = 0;
  endtask

  task automatic model_step(input bit d, input logic [RW-1:0] r, input bit f, input bit rd);
    bit free, cap, send, hit;
    int pre, eff;
    free = !m_valid || rd;
    pre  = m_fill.size();
    cap  = d && (pre < PN);
    hit  = 0;
`ifdef RESCOL_TIMEOUT_EN
    if (pre > 0 && !d && m_idle == TMO - 1) hit = 1;
`endif
    if (cap) m_fill.push_back(r);
    eff  = m_fill.size();
    send = free && (eff == PN || (m_pend && eff > 0));
`ifdef RESCOL_TIMEOUT_EN
    if (cap || send) m_idle = 0;
    else if (pre > 0 && !d) m_idle = (m_idle < TMO) ? m_idle + 1 : m_idle;
    else if (pre == 0) m_idle = 0;
`endif
    if (send) begin
      m_out = m_fill;
      m_valid = 1;
      m_fill.delete();
      m_pend = 0;
      if (d && !cap) m_fill.push_back(r);
    end else begin
      if (d && !cap) begin
        m_ovf = 1;
        if (m_drops < 16'hFFFF) m_drops++;
      end
      if (m_pend || f || hit) m_pend = (eff > 0);
      if (m_valid && rd) m_valid = 0;
    end
  endtask

  task automatic compare_all();
    check_eq("valid", DW'(out_valid_o), DW'(m_valid));
    if (m_valid) begin
      check_eq("count", DW'(out_count_o), DW'(m_out.size()));
      check_eq("data", out_data_o, pack(m_out));
      valid_cycles++;
    end
    check_eq("overflow", DW'(overflow_o), DW'(m_ovf));
    check_eq("drop_cnt", DW'(drop_cnt_o), DW'(m_drops));
  endtask

  task automatic step(input bit d, input logic [RW-1:0] r, input bit f, input bit rd);
    done_i = d; result_i = r; flush_i = f; out_ready_i = rd;
    @(posedge clk_i);
    model_step(d, r, f, rd);
    #1;
    compare_all();
  endtask

  task automatic idle(input int n, input bit rd);
    for (int i = 0; i < n; i++) step(0, '0, 0, rd);
  endtask

  task automatic do_reset();
    #3;
    reset_i = 1'b0;
    #1;
    check_eq("rst_valid", DW'(out_valid_o), '0);
    check_eq("rst_count", DW'(out_count_o), '0);
    check_eq("rst_data", out_data_o, '0);
    check_eq("rst_ovf", DW'(overflow_o), '0);
    check_eq("rst_drops", DW'(drop_cnt_o), '0);
    model_reset();
    done_i = 0; flush_i = 0; out_ready_i = 1; result_i = '0;
    repeat (2) @(posedge clk_i);
    #2;
    reset_i = 1'b1;
    #1;
  endtask

  initial begin
    reset_i = 1'b1; done_i = 0; flush_i = 0; out_ready_i = 1; result_i = '0;
    model_reset();
    #2;
    do_reset();

    // Full batch with ready held high.
    valid_cycles = 0;
    for (int i = 1; i <= PN; i++) step(1, 16'(i), 0, 1);
    check_eq("b1_valid", DW'(out_valid_o), DW'(1));
    check_eq("b1_count", DW'(out_count_o), DW'(20));
    check_eq("b1_lo", DW'(out_data_o[15:0]), DW'(16'h0001));
    check_eq("b1_hi", DW'(out_data_o[319:304]), DW'(16'h0014));
    idle(3, 1);
    check_eq("b1_onecycle", DW'(valid_cycles), DW'(1));
    check_eq("b1_drops", DW'(drop_cnt_o), '0);

    // Partial batch via flush, then next batch starts at slot 0.
    for (int i = 0; i < 7; i++) step(1, 16'hA000 + 16'(i), 0, 0);
    step(0, '0, 1, 0);
    step(0, '0, 0, 0);
    check_eq("p7_count", DW'(out_count_o), DW'(7));
    check_eq("p7_s6", DW'(out_data_o[6*RW +: RW]), DW'(16'hA006));
    check_eq("p7_rest", DW'(out_data_o[DW-1:7*RW]), '0);
    step(0, '0, 0, 1);
    step(1, 16'h5A5A, 1, 1);
    step(0, '0, 0, 1);
    check_eq("p1_slot0", DW'(out_data_o[15:0]), DW'(16'h5A5A));
    idle(2, 1);

    // Backpressure: 45 results with ready low.
    for (int i = 0; i < 45; i++) step(1, 16'h1000 + 16'(i), 0, 0);
    check_eq("bp_drops", DW'(drop_cnt_o), DW'(5));
    check_eq("bp_ovf", DW'(overflow_o), DW'(1));
    check_eq("bp_hold", DW'(out_data_o[15:0]), DW'(16'h1000));
    step(1, 16'h7777, 0, 1);
    check_eq("bp_xfer", DW'(out_data_o[15:0]), DW'(16'h1014));
    step(0, '0, 1, 1);
    step(0, '0, 0, 1);
    check_eq("bp_slot0", DW'(out_data_o[15:0]), DW'(16'h7777));
    check_eq("bp_slot0_cnt", DW'(out_count_o), DW'(1));
    idle(2, 1);

    // Flush with empty buffer, then flush alongside a single result.
    step(0, '0, 1, 1);
    idle(3, 1);
    step(1, 16'hBEEF, 1, 1);
    step(0, '0, 0, 1);
    check_eq("beef_cnt", DW'(out_count_o), DW'(1));
    check_eq("beef_data", out_data_o, DW'(16'hBEEF));
    idle(2, 1);

    // Asynchronous reset mid-batch with the slot occupied.
    for (int i = 0; i < PN + 12; i++) step(1, 16'h2000 + 16'(i), 0, 0);
    check_eq("pre_rst_valid", DW'(out_valid_o), DW'(1));
    do_reset();
    for (int i = 0; i < PN; i++) step(1, 16'h3000 + 16'(i), 0, 0);
    check_eq("post_rst_first", DW'(out_data_o[15:0]), DW'(16'h3000));
    check_eq("post_rst_cnt", DW'(out_count_o), DW'(20));
    idle(1, 1);

    // Idle after a partial batch: emitted only by the auto-flush build.
    for (int i = 0; i < 3; i++) step(1, 16'hC000 + 16'(i), 0, 1);
    valid_cycles = 0;
    idle(200, 1);
`ifdef RESCOL_TIMEOUT_EN
    check_eq("tmo_emitted", DW'(valid_cycles), DW'(1));
`else
    check_eq("no_tmo", DW'(valid_cycles), '0);
    step(0, '0, 1, 1);
    idle(2, 1);
`endif

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 9) < 7, RW'($urandom), $urandom_range(0, 19) == 0,
           $urandom_range(0, 1) == 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    failures++;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
